// File: rtl/pu_msp430_ram_dp_pipe.sv
// Single-clock true dual-port RAM with byte-lane writes, port-A-wins collision
// arbitration, selectable read-during-write mode and 1- or 2-cycle read latency.
module pu_msp430_ram_dp_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_MSB   = 6,
  parameter int MEM_SIZE   = 256,
  parameter int RD_LATENCY = 1,
  parameter int WR_FIRST   = 0
) (
  input  logic                    ram_clk,
  input  logic                    ram_rst_n,
  input  logic [ADDR_MSB:0]       ram_addra,
  input  logic                    ram_cena,
  input  logic [DATA_WIDTH/8-1:0] ram_wena,
  input  logic [DATA_WIDTH-1:0]   ram_dina,
  output logic [DATA_WIDTH-1:0]   ram_douta,
  output logic                    ram_vlda,
  output logic                    ram_erra,
  input  logic [ADDR_MSB:0]       ram_addrb,
  input  logic                    ram_cenb,
  input  logic [DATA_WIDTH/8-1:0] ram_wenb,
  input  logic [DATA_WIDTH-1:0]   ram_dinb,
  output logic [DATA_WIDTH-1:0]   ram_doutb,
  output logic                    ram_vldb,
  output logic                    ram_errb,
  output logic                    ram_coll
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = MEM_SIZE / NB;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  acc_a, acc_b, inr_a, inr_b, same_addr, collide;
  logic [NB-1:0]         we_a, we_b;
  logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;

  always_comb begin
    acc_a     = ~ram_cena;
    acc_b     = ~ram_cenb;
    inr_a     = (32'(ram_addra) < DEPTH);
    inr_b     = (32'(ram_addrb) < DEPTH);
    same_addr = acc_a & acc_b & inr_a & inr_b & (ram_addra == ram_addrb);
    we_a      = (acc_a & inr_a) ? ~ram_wena : '0;
    we_b      = (acc_b & inr_b) ? ~ram_wenb : '0;
    collide   = same_addr & (|(we_a & we_b));
    old_a     = inr_a ? mem[ram_addra] : '0;
    old_b     = inr_b ? mem[ram_addrb] : '0;
    new_a     = old_a;
    new_b     = old_b;
    // Post-write view per lane: own write, else the other port's write to the same word.
    for (int i = 0; i < NB; i++) begin
      if (we_a[i])                     new_a[8*i +: 8] = ram_dina[8*i +: 8];
      else if (same_addr && we_b[i])   new_a[8*i +: 8] = ram_dinb[8*i +: 8];
      if (same_addr && we_a[i])        new_b[8*i +: 8] = ram_dina[8*i +: 8];
      else if (we_b[i])                new_b[8*i +: 8] = ram_dinb[8*i +: 8];
    end
    rd_a = (WR_FIRST != 0) ? new_a : old_a;
    rd_b = (WR_FIRST != 0) ? new_b : old_b;
  end

  // NOTE: the storage array has no reset branch; reset only gates writes, so
  // contents survive reset and the array can map onto block RAM.
  always_ff @(posedge ram_clk) begin
    if (ram_rst_n) begin
      for (int i = 0; i < NB; i++) begin
        if (we_b[i]) mem[ram_addrb][8*i +: 8] <= ram_dinb[8*i +: 8];
        if (we_a[i]) mem[ram_addra][8*i +: 8] <= ram_dina[8*i +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] dout1_a, dout1_b;
  logic                  vld1_a, vld1_b, err1_a, err1_b, coll1;

  always_ff @(posedge ram_clk) begin
    if (!ram_rst_n) begin
      dout1_a <= '0;
      dout1_b <= '0;
      vld1_a  <= 1'b0;
      vld1_b  <= 1'b0;
      err1_a  <= 1'b0;
      err1_b  <= 1'b0;
      coll1   <= 1'b0;
    end else begin
      vld1_a <= acc_a;
      vld1_b <= acc_b;
      err1_a <= acc_a & ~inr_a;
      err1_b <= acc_b & ~inr_b;
      coll1  <= collide;
      if (acc_a) dout1_a <= rd_a;
      if (acc_b) dout1_b <= rd_b;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] dout2_a, dout2_b;
    logic                  vld2_a, vld2_b, err2_a, err2_b, coll2;

    always_ff @(posedge ram_clk) begin
      if (!ram_rst_n) begin
        dout2_a <= '0;
        dout2_b <= '0;
        vld2_a  <= 1'b0;
        vld2_b  <= 1'b0;
        err2_a  <= 1'b0;
        err2_b  <= 1'b0;
        coll2   <= 1'b0;
      end else begin
        vld2_a <= vld1_a;
        vld2_b <= vld1_b;
        err2_a <= err1_a;
        err2_b <= err1_b;
        coll2  <= coll1;
        if (vld1_a) dout2_a <= dout1_a;
        if (vld1_b) dout2_b <= dout1_b;
      end
    end

    assign ram_douta = dout2_a;
    assign ram_doutb = dout2_b;
    assign ram_vlda  = vld2_a;
    assign ram_vldb  = vld2_b;
    assign ram_erra  = err2_a;
    assign ram_errb  = err2_b;
    assign ram_coll  = coll2;
  end else begin : g_lat1
    assign ram_douta = dout1_a;
    assign ram_doutb = dout1_b;
    assign ram_vlda  = vld1_a;
    assign ram_vldb  = vld1_b;
    assign ram_erra  = err1_a;
    assign ram_errb  = err1_b;
    assign ram_coll  = coll1;
  end
endmodule
